// File: rtl/branch_rs.sv
// Branch reservation station: a collapsing queue of branch micro-ops that wait for
// their operands on the CDB and issue oldest-ready-first to the branch comparator.
module branch_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int OP_W  = 10,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_rj,
  input  logic             disp_rk,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [TAG_W-1:0] disp_rob,
  input  logic [31:0]      disp_target,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [31:0]      iss_vj,
  output logic [31:0]      iss_vk,
  output logic [OP_W-1:0]  iss_op,
  output logic [TAG_W-1:0] iss_rob,
  output logic [31:0]      iss_target,
  output logic [CW-1:0]    count
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d, rdy;
  logic [DEPTH-1:0] rj_q, rj_d, rk_q, rk_d, crj, crk;
  logic [OP_W-1:0]  op_q [DEPTH];
  logic [OP_W-1:0]  op_d [DEPTH];
  logic [31:0]      vj_q [DEPTH];
  logic [31:0]      vj_d [DEPTH];
  logic [31:0]      vk_q [DEPTH];
  logic [31:0]      vk_d [DEPTH];
  logic [31:0]      cvj  [DEPTH];
  logic [31:0]      cvk  [DEPTH];
  logic [TAG_W-1:0] qj_q [DEPTH];
  logic [TAG_W-1:0] qj_d [DEPTH];
  logic [TAG_W-1:0] qk_q [DEPTH];
  logic [TAG_W-1:0] qk_d [DEPTH];
  logic [TAG_W-1:0] rob_q [DEPTH];
  logic [TAG_W-1:0] rob_d [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [31:0]      tgt_d [DEPTH];
  logic [CW-1:0]    count_q, count_d, wr_idx;
  logic [IW-1:0]    sel_idx;
  logic             iss_fire, disp_fire, byp_j, byp_k;

  assign rdy        = busy_q & rj_q & rk_q;
  assign iss_valid  = |rdy;
  assign disp_ready = (count_q < CW'(DEPTH));
  assign iss_fire   = iss_valid && iss_ready && !flush;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign wr_idx     = count_q - CW'(iss_fire);
  assign count      = count_q;
  assign byp_j      = !disp_rj && cdb_valid && (disp_qj == cdb_tag);
  assign byp_k      = !disp_rk && cdb_valid && (disp_qk == cdb_tag);

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) sel_idx = IW'(i);
    end
  end

  assign iss_vj     = vj_q[sel_idx];
  assign iss_vk     = vk_q[sel_idx];
  assign iss_op     = op_q[sel_idx];
  assign iss_rob    = rob_q[sel_idx];
  assign iss_target = tgt_q[sel_idx];

  // Capture CDB into every entry first, then collapse over the issued slot, then
  // append the dispatch so shifting entries still see this cycle's broadcast.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cvj[i] = vj_q[i];
      cvk[i] = vk_q[i];
      crj[i] = rj_q[i];
      crk[i] = rk_q[i];
      if (busy_q[i] && !rj_q[i] && cdb_valid && qj_q[i] == cdb_tag) begin
        cvj[i] = cdb_value;
        crj[i] = 1'b1;
      end
      if (busy_q[i] && !rk_q[i] && cdb_valid && qk_q[i] == cdb_tag) begin
        cvk[i] = cdb_value;
        crk[i] = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = busy_q[i];
      op_d[i]   = op_q[i];
      vj_d[i]   = cvj[i];
      vk_d[i]   = cvk[i];
      rj_d[i]   = crj[i];
      rk_d[i]   = crk[i];
      qj_d[i]   = qj_q[i];
      qk_d[i]   = qk_q[i];
      rob_d[i]  = rob_q[i];
      tgt_d[i]  = tgt_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (iss_fire && i >= int'(sel_idx)) begin
        busy_d[i] = busy_q[i+1];
        op_d[i]   = op_q[i+1];
        vj_d[i]   = cvj[i+1];
        vk_d[i]   = cvk[i+1];
        rj_d[i]   = crj[i+1];
        rk_d[i]   = crk[i+1];
        qj_d[i]   = qj_q[i+1];
        qk_d[i]   = qk_q[i+1];
        rob_d[i]  = rob_q[i+1];
        tgt_d[i]  = tgt_q[i+1];
      end
    end
    if (iss_fire) busy_d[DEPTH-1] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && int'(wr_idx) == i) begin
        busy_d[i] = 1'b1;
        op_d[i]   = disp_op;
        vj_d[i]   = byp_j ? cdb_value : disp_vj;
        vk_d[i]   = byp_k ? cdb_value : disp_vk;
        rj_d[i]   = disp_rj | byp_j;
        rk_d[i]   = disp_rk | byp_k;
        qj_d[i]   = disp_qj;
        qk_d[i]   = disp_qk;
        rob_d[i]  = disp_rob;
        tgt_d[i]  = disp_target;
      end
    end
    count_d = count_q + CW'(disp_fire) - CW'(iss_fire);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed behind busy.
  always_ff @(posedge clk) begin
    rj_q <= rj_d;
    rk_q <= rk_d;
    for (int i = 0; i < DEPTH; i++) begin
      op_q[i]  <= op_d[i];
      vj_q[i]  <= vj_d[i];
      vk_q[i]  <= vk_d[i];
      qj_q[i]  <= qj_d[i];
      qk_q[i]  <= qk_d[i];
      rob_q[i] <= rob_d[i];
      tgt_q[i] <= tgt_d[i];
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: a queue-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_branch_rs;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, disp_valid, disp_ready, disp_rj, disp_rk;
  logic [9:0]  disp_op, iss_op;
  logic [31:0] disp_vj, disp_vk, disp_target, cdb_value;
  logic [3:0]  disp_qj, disp_qk, disp_rob, cdb_tag, iss_rob;
  logic        cdb_valid, iss_valid, iss_ready;
  logic [31:0] iss_vj, iss_vk, iss_target;
  logic [2:0]  count;

  int testsRun = 0;
  int testsFailed = 0;
  bit modelValid = 1'b0;

  typedef struct {
    logic [9:0]  op;
    logic [31:0] vj, vk, target;
    logic        rj, rk;
    logic [3:0]  qj, qk, rob;
  } ent_t;

  ent_t mq[$];

  branch_rs #(.DEPTH(DEPTH), .TAG_W(4), .OP_W(10)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_rj(disp_rj), .disp_rk(disp_rk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_rob(disp_rob), .disp_target(disp_target),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_vj(iss_vj), .iss_vk(iss_vk),
    .iss_op(iss_op), .iss_rob(iss_rob), .iss_target(iss_target), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oldestReady();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].rj && mq[i].rk) return i;
    return -1;
  endfunction

  // Reference model: a plain queue; wake, remove the issued one, append the new one.
  always @(posedge clk) begin
    int issueIdx;
    ent_t e;
    if (reset || flush) begin
      mq.delete();
      if (reset) modelValid <= 1'b1;
    end else begin
      issueIdx = iss_ready ? oldestReady() : -1;
      foreach (mq[i]) begin
        if (cdb_valid && !mq[i].rj && mq[i].qj == cdb_tag) begin mq[i].vj = cdb_value; mq[i].rj = 1'b1; end
        if (cdb_valid && !mq[i].rk && mq[i].qk == cdb_tag) begin mq[i].vk = cdb_value; mq[i].rk = 1'b1; end
      end
      if (disp_valid && mq.size() < DEPTH) begin
        e.op = disp_op; e.vj = disp_vj; e.vk = disp_vk; e.rj = disp_rj; e.rk = disp_rk;
        e.qj = disp_qj; e.qk = disp_qk; e.rob = disp_rob; e.target = disp_target;
        if (cdb_valid && !e.rj && e.qj == cdb_tag) begin e.vj = cdb_value; e.rj = 1'b1; end
        if (cdb_valid && !e.rk && e.qk == cdb_tag) begin e.vk = cdb_value; e.rk = 1'b1; end
      end
      if (issueIdx >= 0) mq.delete(issueIdx);
      if (disp_valid && mq.size() + (issueIdx >= 0 ? 1 : 0) < DEPTH) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    int s;
    if (modelValid) begin
      s = oldestReady();
      checkOutput("model_count", 32'(count), 32'(mq.size()));
      checkOutput("model_disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
      checkOutput("model_iss_valid", 32'(iss_valid), 32'(s >= 0));
      if (s >= 0) begin
        checkOutput("model_iss_rob", 32'(iss_rob), 32'(mq[s].rob));
        checkOutput("model_iss_vj", iss_vj, mq[s].vj);
        checkOutput("model_iss_vk", iss_vk, mq[s].vk);
        checkOutput("model_iss_op", 32'(iss_op), 32'(mq[s].op));
        checkOutput("model_iss_target", iss_target, mq[s].target);
      end
    end
  end

  task automatic setDisp(input logic [9:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic rj, input logic rk, input logic [3:0] qj, input logic [3:0] qk,
                         input logic [3:0] rob, input logic [31:0] target);
    disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk; disp_rj = rj; disp_rk = rk;
    disp_qj = qj; disp_qk = qk; disp_rob = rob; disp_target = target;
  endtask

  task automatic setCdb(input logic [3:0] tag, input logic [31:0] value);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
  endtask

  // Commits the currently driven inputs across one rising edge, then idles them.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    reset = 1'b0; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; iss_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; iss_ready = 1'b0;
    disp_op = '0; disp_vj = '0; disp_vk = '0; disp_rj = 1'b0; disp_rk = 1'b0;
    disp_qj = '0; disp_qk = '0; disp_rob = '0; disp_target = '0; cdb_tag = '0; cdb_value = '0;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkOutput("reset_count", 32'(count), 0);
    checkOutput("reset_iss_valid", 32'(iss_valid), 0);
    checkOutput("reset_disp_ready", 32'(disp_ready), 1);

    // BEQ with both operands ready
    setDisp(10'h000, 5, 5, 1, 1, 0, 0, 3, 32'h100);
    applyStimulus();
    checkOutput("beq_iss_valid", 32'(iss_valid), 1);
    checkOutput("beq_iss_vj", iss_vj, 5);
    checkOutput("beq_iss_vk", iss_vk, 5);
    checkOutput("beq_iss_rob", 32'(iss_rob), 3);
    checkOutput("beq_count", 32'(count), 1);
    iss_ready = 1'b1;
    applyStimulus();
    checkOutput("beq_drain_count", 32'(count), 0);
    checkOutput("beq_drain_valid", 32'(iss_valid), 0);

    // BLT waiting on tag 7, woken two cycles later
    setDisp(10'h200, 0, 10, 0, 1, 7, 0, 4, 32'h200);
    applyStimulus();
    checkOutput("blt_wait_valid", 32'(iss_valid), 0);
    applyStimulus();
    setCdb(7, 32'hFFFF_FFFF);
    checkOutput("blt_wake_same_cycle", 32'(iss_valid), 0);
    applyStimulus();
    checkOutput("blt_woken_valid", 32'(iss_valid), 1);
    checkOutput("blt_woken_vj", iss_vj, 32'hFFFF_FFFF);
    checkOutput("blt_woken_vk", iss_vk, 10);
    iss_ready = 1'b1;
    applyStimulus();

    // Dispatch-time CDB bypass
    setDisp(10'h080, 0, 1, 0, 1, 2, 0, 5, 32'h300);
    setCdb(2, 32'h40);
    applyStimulus();
    checkOutput("bypass_valid", 32'(iss_valid), 1);
    checkOutput("bypass_vj", iss_vj, 32'h40);
    iss_ready = 1'b1;
    applyStimulus();

    // Oldest entry waits; younger ready entries issue around it
    setDisp(10'h000, 0, 1, 0, 1, 9, 0, 0, 32'h400); applyStimulus();
    setDisp(10'h080, 1, 2, 1, 1, 0, 0, 1, 32'h404); applyStimulus();
    setDisp(10'h080, 3, 4, 1, 1, 0, 0, 2, 32'h408); applyStimulus();
    setDisp(10'h080, 5, 6, 1, 1, 0, 0, 3, 32'h40C); applyStimulus();
    checkOutput("fill_count", 32'(count), 4);
    checkOutput("fill_disp_ready", 32'(disp_ready), 0);
    checkOutput("fill_iss_rob", 32'(iss_rob), 1);
    iss_ready = 1'b1; applyStimulus();
    checkOutput("order_rob2", 32'(iss_rob), 2);
    checkOutput("order_count3", 32'(count), 3);
    iss_ready = 1'b1; applyStimulus();
    checkOutput("order_rob3", 32'(iss_rob), 3);
    iss_ready = 1'b1; applyStimulus();
    checkOutput("order_count1", 32'(count), 1);
    checkOutput("order_wait_valid", 32'(iss_valid), 0);
    setCdb(9, 7); applyStimulus();
    checkOutput("late_wake_rob", 32'(iss_rob), 0);
    checkOutput("late_wake_vj", iss_vj, 7);
    iss_ready = 1'b1; applyStimulus();
    checkOutput("late_drain_count", 32'(count), 0);

    // Full station: same-cycle issue does not open a dispatch slot
    for (int i = 0; i < 4; i++) begin
      setDisp(10'h100, 32'(i), 32'(i + 1), 1, 1, 0, 0, 4'(8 + i), 32'(32'h500 + 4 * i));
      applyStimulus();
    end
    setDisp(10'h100, 9, 9, 1, 1, 0, 0, 12, 32'h600);
    iss_ready = 1'b1; applyStimulus();
    checkOutput("full_reject_count", 32'(count), 3);
    checkOutput("full_next_rob", 32'(iss_rob), 9);
    setDisp(10'h100, 9, 9, 1, 1, 0, 0, 12, 32'h600);
    applyStimulus();
    checkOutput("full_accept_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("full_drain_rob", 32'(iss_rob), 32'(9 + i));
      iss_ready = 1'b1; applyStimulus();
    end

    // Flush overrides dispatch and issue; later CDB does nothing
    setDisp(10'h000, 0, 0, 0, 1, 6, 0, 1, 32'h700); applyStimulus();
    setDisp(10'h000, 0, 0, 0, 1, 6, 0, 2, 32'h704); applyStimulus();
    setDisp(10'h000, 1, 1, 1, 1, 0, 0, 3, 32'h708); applyStimulus();
    checkOutput("preflush_count", 32'(count), 3);
    setDisp(10'h000, 2, 2, 1, 1, 0, 0, 4, 32'h70C);
    flush = 1'b1; iss_ready = 1'b1; applyStimulus();
    checkOutput("flush_count", 32'(count), 0);
    checkOutput("flush_iss_valid", 32'(iss_valid), 0);
    setCdb(6, 32'h1234); applyStimulus();
    checkOutput("postflush_valid", 32'(iss_valid), 0);
    checkOutput("postflush_count", 32'(count), 0);
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
